// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master transmitter: divided bit clock, word select, MSB-first stereo data.
// One-frame holding register fed by valid/ready; the active frame repeats on underrun.
module i2s_transmitter #(
    parameter int WIDTH     = 24,
    parameter int SCLK_HALF = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] sample_l_in,
    input  logic [WIDTH-1:0] sample_r_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             sclk_out,
    output logic             ws_out,
    output logic             sdata_out,
    output logic             frame_start_out,
    output logic             underrun_out
);

    localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_HALF - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic [5:0]       slot_q, slot_d;
    logic             ws_q, ws_d;
    logic             sdata_q, sdata_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] active_l_q, active_l_d, active_r_q, active_r_d;

    logic             tc, fall, boundary, accept;
    logic [4:0]       pos, idx;
    logic [WIDTH-1:0] word;

    always_comb begin
        tc       = (cnt_q == CNT_LAST);
        cnt_d    = tc ? '0 : cnt_q + 1'b1;
        sclk_d   = tc ? ~sclk_q : sclk_q;
        fall     = tc & sclk_q;
        slot_d   = fall ? slot_q + 6'd1 : slot_q;
        boundary = fall && (slot_q == 6'd63);
        accept   = valid_in & ~full_q;

        // A full holding register is promoted at the boundary so its MSB leaves in that same cycle.
        active_l_d = (boundary && full_q) ? hold_l_q : active_l_q;
        active_r_d = (boundary && full_q) ? hold_r_q : active_r_q;

        hold_l_d = accept ? sample_l_in : hold_l_q;
        hold_r_d = accept ? sample_r_in : hold_r_q;
        if (boundary && full_q) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
        end else begin
            full_d = full_q;
        end

        frame_start_d = boundary;
        underrun_d    = boundary & ~full_q;

        pos  = slot_d[4:0];
        idx  = 5'(WIDTH - 1) - pos;
        word = slot_d[5] ? active_r_d : active_l_d;
        ws_d    = ws_q;
        sdata_d = sdata_q;
        if (fall) begin
            ws_d    = (slot_d >= 6'd31) && (slot_d <= 6'd62);
            sdata_d = ({1'b0, pos} < 6'(WIDTH)) ? word[idx] : 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q         <= '0;
            sclk_q        <= 1'b0;
            slot_q        <= 6'd63;
            ws_q          <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            full_q        <= 1'b0;
            active_l_q    <= '0;
            active_r_q    <= '0;
        end else begin
            cnt_q         <= cnt_d;
            sclk_q        <= sclk_d;
            slot_q        <= slot_d;
            ws_q          <= ws_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            full_q        <= full_d;
            active_l_q    <= active_l_d;
            active_r_q    <= active_r_d;
        end
    end

    assign ready_out       = ~full_q;
    assign sclk_out        = sclk_q;
    assign ws_out          = ws_q;
    assign sdata_out       = sdata_q;
    assign frame_start_out = frame_start_q;
    assign underrun_out    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - directed self-checking bench for i2s_transmitter.
module tb_i2s_transmitter;

    localparam int WIDTH     = 24;
    localparam int SCLK_HALF = 16;
    localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic [WIDTH-1:0] sample_l_in = '0;
    logic [WIDTH-1:0] sample_r_in = '0;
    logic             valid_in = 1'b0;
    logic             ready_out, sclk_out, ws_out, sdata_out, frame_start_out, underrun_out;

    int n_checks = 0;
    int n_fail   = 0;

    i2s_transmitter #(.WIDTH(WIDTH), .SCLK_HALF(SCLK_HALF)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_l_in     (sample_l_in),
        .sample_r_in     (sample_r_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .sclk_out        (sclk_out),
        .ws_out          (ws_out),
        .sdata_out       (sdata_out),
        .frame_start_out (frame_start_out),
        .underrun_out    (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_boundary(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start_out && n < 3000);
        n_checks++;
        if (!frame_start_out) begin
            n_fail++;
            $display("FAIL wait_boundary: no frame_start_out within %0d cycles", n);
        end
    endtask

    task automatic capture_frame(output logic [63:0] d, output logic [63:0] w);
        int s = 0;
        int guard = 0;
        logic prev = sclk_out;
        d = '0;
        w = '0;
        while (s < 64 && guard < 2200) begin
            step();
            guard++;
            if (!prev && sclk_out) begin
                d[63-s] = sdata_out;
                w[63-s] = ws_out;
                s++;
            end
            prev = sclk_out;
        end
        n_checks++;
        if (s != 64) begin
            n_fail++;
            $display("FAIL capture_frame: got %0d sclk rises, required 64", s);
        end
    endtask

    task automatic send_one(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        sample_l_in = l;
        sample_r_in = r;
        valid_in    = 1'b1;
        n_checks++;
        if (ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: ready_out=%b required 1", ready_out);
        end
        step();
        valid_in = 1'b0;
        n_checks++;
        if (ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL send_full: ready_out=%b required 0", ready_out);
        end
    endtask

    task automatic check_reset_timing(input string tag);
        logic exp_sclk, exp_pulse;
        for (int e = 1; e <= 2 * SCLK_HALF; e++) begin
            step();
            exp_sclk  = (e >= SCLK_HALF) && (e < 2 * SCLK_HALF);
            exp_pulse = (e == 2 * SCLK_HALF);
            n_checks++;
            if (sclk_out !== exp_sclk) begin
                n_fail++;
                $display("FAIL %s sclk edge %0d: got %b required %b", tag, e, sclk_out, exp_sclk);
            end
            n_checks++;
            if (frame_start_out !== exp_pulse || underrun_out !== exp_pulse) begin
                n_fail++;
                $display("FAIL %s pulses edge %0d: fs=%b ur=%b required %b", tag, e,
                         frame_start_out, underrun_out, exp_pulse);
            end
            n_checks++;
            if (ws_out !== 1'b0 || sdata_out !== 1'b0 || ready_out !== 1'b1) begin
                n_fail++;
                $display("FAIL %s idle edge %0d: ws=%b sdata=%b ready=%b required 0 0 1", tag, e,
                         ws_out, sdata_out, ready_out);
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({ready_out, sclk_out, ws_out, sdata_out, frame_start_out, underrun_out} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 100000",
                     {ready_out, sclk_out, ws_out, sdata_out, frame_start_out, underrun_out});
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        check_reset_timing("reset");
    endtask

    task automatic test_bit_order();
        logic [63:0] d, w;
        int n;
        send_one(24'hA5A5A5, 24'h3C3C3C);
        wait_boundary(n);
        n_checks++;
        if (underrun_out !== 1'b0 || ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bit_order_boundary: ur=%b ready=%b required 0 1", underrun_out, ready_out);
        end
        capture_frame(d, w);
        n_checks++;
        if (d !== {24'hA5A5A5, 8'h00, 24'h3C3C3C, 8'h00}) begin
            n_fail++;
            $display("FAIL bit_order_data: got %h required %h", d, {24'hA5A5A5, 8'h00, 24'h3C3C3C, 8'h00});
        end
        n_checks++;
        if (w !== WS_EXP) begin
            n_fail++;
            $display("FAIL bit_order_ws: got %h required %h", w, WS_EXP);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d, w;
        int n;
        sample_l_in = 24'h000001;
        sample_r_in = 24'h000002;
        valid_in    = 1'b1;
        n_checks++;
        if (ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_first: got %b required 1", ready_out);
        end
        step();
        sample_l_in = 24'h000003;
        sample_r_in = 24'h000004;
        n_checks++;
        if (ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_fall: got %b required 0", ready_out);
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!ready_out && n < 3000);
        n_checks++;
        if (frame_start_out !== 1'b1 || underrun_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: fs=%b ur=%b after %0d cycles required 1 0", frame_start_out,
                     underrun_out, n);
        end
        step();
        valid_in = 1'b0;
        n_checks++;
        if (ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_accept: ready=%b required 0", ready_out);
        end
        capture_frame(d, w);
        n_checks++;
        if (d !== {24'h000001, 8'h00, 24'h000002, 8'h00}) begin
            n_fail++;
            $display("FAIL bp_frame1: got %h required %h", d, {24'h000001, 8'h00, 24'h000002, 8'h00});
        end
        wait_boundary(n);
        n_checks++;
        if (underrun_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_boundary2_ur: got %b required 0", underrun_out);
        end
        capture_frame(d, w);
        n_checks++;
        if (d !== {24'h000003, 8'h00, 24'h000004, 8'h00}) begin
            n_fail++;
            $display("FAIL bp_frame2: got %h required %h", d, {24'h000003, 8'h00, 24'h000004, 8'h00});
        end
    endtask

    task automatic test_underrun();
        logic [63:0] d, w;
        int n;
        send_one(24'h123456, 24'h654321);
        wait_boundary(n);
        n_checks++;
        if (underrun_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_first_boundary: got %b required 0", underrun_out);
        end
        capture_frame(d, w);
        n_checks++;
        if (d !== {24'h123456, 8'h00, 24'h654321, 8'h00}) begin
            n_fail++;
            $display("FAIL ur_frame_first: got %h required %h", d, {24'h123456, 8'h00, 24'h654321, 8'h00});
        end
        wait_boundary(n);
        n_checks++;
        if (underrun_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ur_pulse: got %b required 1", underrun_out);
        end
        step();
        n_checks++;
        if (underrun_out !== 1'b0 || frame_start_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_pulse_width: ur=%b fs=%b required 0 0", underrun_out, frame_start_out);
        end
        capture_frame(d, w);
        n_checks++;
        if (d !== {24'h123456, 8'h00, 24'h654321, 8'h00}) begin
            n_fail++;
            $display("FAIL ur_frame_repeat: got %h required %h", d, {24'h123456, 8'h00, 24'h654321, 8'h00});
        end
        n_checks++;
        if (w !== WS_EXP) begin
            n_fail++;
            $display("FAIL ur_ws_repeat: got %h required %h", w, WS_EXP);
        end
    endtask

    task automatic test_boundary_handshake();
        logic [63:0] d, w;
        int n;
        // capture_frame returns at the last slot's rise, SCLK_HALF cycles before the boundary
        repeat (SCLK_HALF - 1) step();
        sample_l_in = 24'h7FFFFF;
        sample_r_in = 24'h800000;
        valid_in    = 1'b1;
        step();
        valid_in = 1'b0;
        n_checks++;
        if (frame_start_out !== 1'b1 || underrun_out !== 1'b1 || ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bh_boundary: fs=%b ur=%b ready=%b required 1 1 0", frame_start_out,
                     underrun_out, ready_out);
        end
        capture_frame(d, w);
        n_checks++;
        if (d !== {24'h123456, 8'h00, 24'h654321, 8'h00}) begin
            n_fail++;
            $display("FAIL bh_frame_old: got %h required %h", d, {24'h123456, 8'h00, 24'h654321, 8'h00});
        end
        wait_boundary(n);
        n_checks++;
        if (underrun_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bh_next_ur: got %b required 0", underrun_out);
        end
        capture_frame(d, w);
        n_checks++;
        if (d !== {24'h7FFFFF, 8'h00, 24'h800000, 8'h00}) begin
            n_fail++;
            $display("FAIL bh_frame_new: got %h required %h", d, {24'h7FFFFF, 8'h00, 24'h800000, 8'h00});
        end
    endtask

    task automatic test_midframe_reset();
        logic [63:0] d, w;
        int n;
        wait_boundary(n);
        send_one(24'h111111, 24'h222222);
        // slot 40 begins 40 sclk periods after the boundary
        repeat (40 * 2 * SCLK_HALF + 8) step();
        n_checks++;
        if (ws_out !== 1'b1 || sclk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_pre: ws=%b sclk=%b required 1 0", ws_out, sclk_out);
        end
        #2;
        rst_in = 1'b0;
        #1;
        n_checks++;
        if ({ready_out, sclk_out, ws_out, sdata_out, frame_start_out, underrun_out} !== 6'b100000) begin
            n_fail++;
            $display("FAIL mr_async: got %b required 100000",
                     {ready_out, sclk_out, ws_out, sdata_out, frame_start_out, underrun_out});
        end
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        check_reset_timing("midreset");
        wait_boundary(n);
        n_checks++;
        if (n != 128 * SCLK_HALF) begin
            n_fail++;
            $display("FAIL mr_period: got %0d required %0d", n, 128 * SCLK_HALF);
        end
        n_checks++;
        if (underrun_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_underrun: got %b required 1", underrun_out);
        end
        capture_frame(d, w);
        n_checks++;
        if (d !== 64'h0 || w !== WS_EXP) begin
            n_fail++;
            $display("FAIL mr_frame: data %h ws %h required 0 and %h", d, w, WS_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_backpressure();
        test_underrun();
        test_boundary_handshake();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Generates I2S master clocks and serial data from parallel stereo samples. It drives an external I2S DAC/codec, mirroring the clocking used on the microphone input path. It sits downstream of the audio processing chain as an alternative output to the PDM speaker path. Samples enter through a valid/ready handshake into a one-frame holding register. Frames are transmitted continuously, and the last frame is repeated on underrun.

## Interface
- WIDTH, 24: sample width per channel; must satisfy 1 ≤ WIDTH ≤ 32.
- SCLK_HALF, 16: clk_in cycles per sclk half-period. sclk = clk/(2·SCLK_HALF); frame = 64·2·SCLK_HALF clk cycles.
- clk_in  input  1  system clock, 100 MHz; the only clock.
- rst_in  input  1  reset, asynchronous and active-low.
- sample_l_in  input  WIDTH  left-channel sample, two's complement.
- sample_r_in  input  WIDTH  right-channel sample, two's complement.
- valid_in  input  1  sample pair valid; transfer occurs when valid_in && ready_out at a clk_in edge.
- ready_out  output  1  holding register empty.
- sclk_out  output  1  I2S bit clock.
- ws_out  output  1  word select: 0 = left, 1 = right.
- sdata_out  output  1  serial data, MSB first.
- frame_start_out  output  1  one-cycle pulse at each frame boundary.
- underrun_out  output  1  one-cycle pulse when a frame boundary finds the holding register empty.

## Operation
- Divider cnt runs 0..SCLK_HALF-1. At terminal count, cnt wraps and sclk toggles.
  - Rising-edge event: sclk goes 0→1.
  - Falling-edge event: sclk goes 1→0.
- Slot counter b is 6 bits, counts 0..63, and wraps 63→0. It advances only on falling-edge events.
- ws_out, sdata_out, frame_start_out and underrun_out are all registered. They update only in the same cycle sclk_out falls, so they are stable at the rising sclk edge.
- ws_out is 1 for b in 31..62 and 0 for b in 63 and 0..30. WS therefore changes one slot before each channel's MSB (standard I2S).
- sdata_out for slot b:
  - b in 0..WIDTH-1: active_l[WIDTH-1-b].
  - b in 32..32+WIDTH-1: active_r[WIDTH-1-(b-32)].
  - All other slots: 0.
- Holding register (hold_l, hold_r, full):
  - ready_out = !full.
  - A handshake loads the holding register and sets full.
- Frame boundary is the falling-edge event where b goes 63→0. In that cycle frame_start_out pulses, and:
  - If full: active_l/active_r ← hold, and full clears. ready_out is high from the next cycle.
  - If not full: underrun_out pulses and the active registers keep their previous contents, so the frame is repeated.
- A handshake in the same cycle as a boundary that finds full = 0 is accepted into the holding register. That boundary still reports underrun; there is no bypass. The sample is transmitted at the following boundary.
- Reset (rst_in = 0), applied asynchronously at any time including mid-frame:
  - cnt = 0, b = 63, sclk_out = 0, ws_out = 0, sdata_out = 0.
  - frame_start_out = 0, underrun_out = 0.
  - full = 0, so ready_out = 1.
  - active_l = active_r = 0.

## Timing
- After rst_in deasserts, count clk_in edges from 1:
  - First sclk rise at edge SCLK_HALF.
  - First fall, and the first frame boundary (b = 0), at edge 2·SCLK_HALF.
- Frame period: 128·SCLK_HALF cycles (2048 at default). Boundaries occur every 2048 cycles.
- Latency:
  - A sample accepted before boundary k has its MSB on sdata_out in the boundary-k cycle.
  - The receiver samples that MSB SCLK_HALF cycles later.
- Throughput: at most one sample pair per frame. ready_out is low from acceptance until the cycle after the next boundary.
- underrun_out and frame_start_out are exactly one clk_in cycle wide.

## Test plan
- Reset check: hold rst_in low, then release.
  - While low: all outputs 0 except ready_out = 1.
  - sclk_out rises at edge 16 and falls at edge 32.
  - frame_start_out and underrun_out pulse at edge 32; ws_out = 0 and sdata_out = 0 (active regs zero).
- Bit order: load L = 0xA5A5A5, R = 0x3C3C3C before a boundary, then sample sdata_out on sclk rises.
  - Slots 0..23 = A5A5A5 MSB first; slots 24..31 = 0.
  - Slots 32..55 = 3C3C3C; slots 56..63 = 0.
  - ws_out = 1 exactly for slots 31..62.
- Backpressure: hold valid_in high with pairs (0x000001, 0x000002), (0x000003, 0x000004).
  - The first is accepted immediately and ready_out falls.
  - The second is accepted in the cycle after the next boundary.
  - Consecutive frames carry 1/2, then 3/4.
- Underrun: after one frame of 0x123456 / 0x654321, stop valid_in.
  - Each following boundary pulses underrun_out.
  - The serial stream repeats 0x123456 / 0x654321 unchanged.
- Simultaneous boundary handshake: assert valid_in with 0x7FFFFF / 0x800000 in exactly the boundary cycle while empty.
  - underrun_out pulses.
  - The data appears one frame later.
- Mid-frame reset: assert rst_in low at slot 40 for 3 cycles.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - A pending held sample is discarded.
  - The timing after release matches the reset check; measured frame period is 2048 cycles.
